// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM-style bus initiator.
package sram_bus_pkg;

  localparam int ADDR_W_DEF = 21;
  localparam int DATA_W_DEF = 16;

  localparam logic [DATA_W_DEF-1:0] LANE_MASK_LO = 16'h00FF;
  localparam logic [DATA_W_DEF-1:0] LANE_MASK_HI = 16'hFF00;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_TURN   = 3'd4
  } bus_state_e;

  // The timer is loaded with count-1, so it only has to hold the largest phase minus one.
  function automatic int cnt_width(input int s, input int t, input int h, input int u);
    int m;
    m = s;
    if (t > m) m = t;
    if (h > m) m = h;
    if (u > m) m = u;
    if (m < 2) return 1;
    else return $clog2(m);
  endfunction

  function automatic logic [DATA_W_DEF-1:0] lane_mask(input logic [1:0] be);
    lane_mask = (be[1] ? LANE_MASK_HI : 16'h0000) | (be[0] ? LANE_MASK_LO : 16'h0000);
  endfunction

endpackage

// File: rtl/sram_cycle_timer.sv
// Loadable down-counter; last is high while the count is zero.
module sram_cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] count_r;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign last = (count_r == {W{1'b0}});

endmodule

// File: rtl/sram_bus_master.sv
// Turns valid/ready requests into timed async-SRAM read/write cycles.
module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int TURN_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i
);

  localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC);

  bus_state_e        state_r, next_s;
  logic              write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [1:0]        be_r;

  logic              accept_s, last_s, load_s;
  logic [CNT_W-1:0]  load_val_s;
  logic              cur_write_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [DATA_W-1:0] cur_wdata_s;
  logic [1:0]        cur_be_s;

  function automatic logic [CNT_W-1:0] phase_load(input bus_state_e p);
    case (p)
      S_SETUP:  phase_load = CNT_W'(SETUP_CYC - 1);
      S_STROBE: phase_load = CNT_W'(STROBE_CYC - 1);
      S_HOLD:   phase_load = CNT_W'(HOLD_CYC - 1);
      S_TURN:   phase_load = CNT_W'(TURN_CYC - 1);
      default:  phase_load = {CNT_W{1'b0}};
    endcase
  endfunction

  assign req_ready = (state_r == S_IDLE) && !rst;

  // Successor phase and timer reload; zero-length phases are never entered.
  always_comb begin
    accept_s = req_valid && req_ready;
    if (accept_s) begin
      cur_write_s = req_write;
      cur_addr_s  = req_addr;
      cur_wdata_s = req_wdata;
      cur_be_s    = req_be;
    end else begin
      cur_write_s = write_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_be_s    = be_r;
    end
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!accept_s)             next_s = S_IDLE;
        else if (req_be == 2'b00)  next_s = S_IDLE;
        else if (SETUP_CYC > 0)    next_s = S_SETUP;
        else                       next_s = S_STROBE;
      end
      S_SETUP: begin
        if (last_s) next_s = S_STROBE;
        else        next_s = S_SETUP;
      end
      S_STROBE: begin
        if (!last_s)                       next_s = S_STROBE;
        else if (HOLD_CYC > 0)             next_s = S_HOLD;
        else if (!write_r && TURN_CYC > 0) next_s = S_TURN;
        else                               next_s = S_IDLE;
      end
      S_HOLD: begin
        if (!last_s)                       next_s = S_HOLD;
        else if (!write_r && TURN_CYC > 0) next_s = S_TURN;
        else                               next_s = S_IDLE;
      end
      S_TURN: begin
        if (last_s) next_s = S_IDLE;
        else        next_s = S_TURN;
      end
      default: next_s = S_IDLE;
    endcase
    if (state_r == S_IDLE) load_s = accept_s;
    else                   load_s = last_s;
    load_val_s = phase_load(next_s);
  end

  sram_cycle_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .last     (last_s)
  );

  // State, request latch and bus outputs, all registered from the phase being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      write_r    <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      be_r       <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= {DATA_W{1'b0}};
      sram_a     <= {ADDR_W{1'b0}};
      sram_cs_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_dq_o  <= {DATA_W{1'b0}};
      sram_dq_oe <= 1'b0;
    end else begin
      state_r <= next_s;
      if (accept_s) begin
        write_r <= req_write;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        be_r    <= req_be;
      end
      rsp_valid <= (state_r == S_STROBE && last_s) || (accept_s && req_be == 2'b00);
      if (accept_s && req_be == 2'b00) begin
        rsp_rdata <= {DATA_W{1'b0}};
      end else if (state_r == S_STROBE && last_s && !write_r) begin
        rsp_rdata <= sram_dq_i & DATA_W'(lane_mask(be_r));
      end
      case (next_s)
        S_SETUP, S_STROBE, S_HOLD: begin
          sram_a     <= cur_addr_s;
          sram_cs_n  <= 1'b0;
          sram_ub_n  <= ~cur_be_s[1];
          sram_lb_n  <= ~cur_be_s[0];
          sram_oe_n  <= !((next_s == S_STROBE) && !cur_write_s);
          sram_we_n  <= !((next_s == S_STROBE) && cur_write_s);
          sram_dq_oe <= cur_write_s;
          if (cur_write_s) sram_dq_o <= cur_wdata_s;
        end
        default: begin
          sram_cs_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule
